// File: rtl/rf_write_arbiter.sv
// rtl/rf_write_arbiter.sv - round-robin writeback arbiter for the register-file write port
// with a per-register pending-write scoreboard driving the decode read-hazard stall.
module rf_write_arbiter #(
  parameter int XLEN   = 32,
  parameter int AWIDTH = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [AWIDTH-1:0] req0_addr,
  input  logic [XLEN-1:0]   req0_data,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [AWIDTH-1:0] req1_addr,
  input  logic [XLEN-1:0]   req1_data,
  input  logic              rsv_valid,
  input  logic [AWIDTH-1:0] rsv_addr,
  input  logic [AWIDTH-1:0] ra1,
  input  logic [AWIDTH-1:0] ra2,
  output logic              stall,
  output logic              rf_we,
  output logic [AWIDTH-1:0] rf_wa,
  output logic [XLEN-1:0]   rf_wd
);

  localparam int   NREG    = 2**AWIDTH;
  localparam logic RR_REQ0 = 1'b0;
  localparam logic RR_REQ1 = 1'b1;

  logic              rr;
  logic              contested;
  logic              gnt0;
  logic              gnt1;
  logic [AWIDTH-1:0] gnt_addr;
  logic [XLEN-1:0]   gnt_data;
  logic [NREG-1:0]   busy;

  // The port drains every cycle, so the grant depends only on valids and rr.
  always_comb begin
    contested = req0_valid && req1_valid;
    gnt0      = 1'b0;
    gnt1      = 1'b0;
    if (rst_n) begin
      if (contested) begin
        gnt0 = (rr == RR_REQ0);
        gnt1 = (rr == RR_REQ1);
      end else begin
        gnt0 = req0_valid;
        gnt1 = req1_valid;
      end
    end
    gnt_addr = gnt1 ? req1_addr : req0_addr;
    gnt_data = gnt1 ? req1_data : req0_data;
  end

  assign req0_ready = gnt0;
  assign req1_ready = gnt1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr    <= RR_REQ0;
      rf_we <= 1'b0;
      rf_wa <= '0;
      rf_wd <= '0;
    end else begin
      if (contested) begin
        rr <= ~rr;
      end
      // x0 is granted so the requester retires, but nothing is written.
      rf_we <= (gnt0 || gnt1) && (gnt_addr != '0);
      if (gnt0 || gnt1) begin
        rf_wa <= gnt_addr;
        rf_wd <= gnt_data;
      end
    end
  end

  // A reservation landing on the same edge as a commit is a new outstanding write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= '0;
    end else begin
      for (int i = 1; i < NREG; i++) begin
        if (rsv_valid && rsv_addr == AWIDTH'(i)) begin
          busy[i] <= 1'b1;
        end else if (rf_we && rf_wa == AWIDTH'(i)) begin
          busy[i] <= 1'b0;
        end
      end
    end
  end

  assign stall = ((ra1 != '0) && busy[ra1]) || ((ra2 != '0) && busy[ra2]);

endmodule

// File: tb/tb_rf_write_arbiter.sv
// tb/tb_rf_write_arbiter.sv - directed and randomized bench for rf_write_arbiter
// against a behavioural scoreboard/arbiter model.
module tb_rf_write_arbiter;

  localparam int XLEN   = 32;
  localparam int AWIDTH = 5;
  localparam int NREG   = 32;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              req0_valid = 1'b0;
  logic              req0_ready;
  logic [AWIDTH-1:0] req0_addr = '0;
  logic [XLEN-1:0]   req0_data = '0;
  logic              req1_valid = 1'b0;
  logic              req1_ready;
  logic [AWIDTH-1:0] req1_addr = '0;
  logic [XLEN-1:0]   req1_data = '0;
  logic              rsv_valid = 1'b0;
  logic [AWIDTH-1:0] rsv_addr = '0;
  logic [AWIDTH-1:0] ra1 = '0;
  logic [AWIDTH-1:0] ra2 = '0;
  logic              stall;
  logic              rf_we;
  logic [AWIDTH-1:0] rf_wa;
  logic [XLEN-1:0]   rf_wd;

  rf_write_arbiter #(.XLEN(XLEN), .AWIDTH(AWIDTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_addr(req0_addr), .req0_data(req0_data),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_addr(req1_addr), .req1_data(req1_data),
    .rsv_valid(rsv_valid), .rsv_addr(rsv_addr), .ra1(ra1), .ra2(ra2),
    .stall(stall), .rf_we(rf_we), .rf_wa(rf_wa), .rf_wd(rf_wd)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AWIDTH-1:0] a;
    logic [XLEN-1:0]   d;
  } wr_t;

  int checks = 0;
  int failures = 0;

  // Reference model: which side is favoured on a tie, which registers await a write,
  // and what the write port should show next cycle.
  bit                m_busy[NREG];
  int                m_favour;
  logic              m_we;
  logic [AWIDTH-1:0] m_wa;
  logic [XLEN-1:0]   m_wd;
  logic              e0, e1;
  wr_t               q0[$];
  wr_t               q1[$];
  int                wr_count;
  logic [7:0]        glog;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    foreach (m_busy[i]) m_busy[i] = 1'b0;
    m_favour = 0;
    m_we = 1'b0;
    m_wa = '0;
    m_wd = '0;
  endtask

  function automatic logic model_stall();
    return (ra1 != 0 && m_busy[ra1]) || (ra2 != 0 && m_busy[ra2]);
  endfunction

  task automatic drive_heads();
    req0_valid = (q0.size() > 0);
    req1_valid = (q1.size() > 0);
    if (q0.size() > 0) begin req0_addr = q0[0].a; req0_data = q0[0].d; end
    if (q1.size() > 0) begin req1_addr = q1[0].a; req1_data = q1[0].d; end
  endtask

  task automatic pop_granted();
    if (e0) void'(q0.pop_front());
    if (e1) void'(q1.pop_front());
  endtask

  // Called at posedge+1 with inputs applied; returns at the next posedge+1.
  task automatic cycle(input string tag);
    bit nb[NREG];
    #1;
    e0 = 1'b0;
    e1 = 1'b0;
    if (req0_valid && req1_valid) begin
      if (m_favour == 0) e0 = 1'b1; else e1 = 1'b1;
    end else if (req0_valid) begin
      e0 = 1'b1;
    end else if (req1_valid) begin
      e1 = 1'b1;
    end
    chk({tag, ":req0_ready"}, req0_ready, e0);
    chk({tag, ":req1_ready"}, req1_ready, e1);
    chk({tag, ":stall"}, stall, model_stall());
    glog = {glog[6:0], req0_ready};
    nb = m_busy;
    if (m_we) nb[m_wa] = 1'b0;
    if (rsv_valid && rsv_addr != 0) nb[rsv_addr] = 1'b1;
    m_busy = nb;
    if (req0_valid && req1_valid) m_favour = 1 - m_favour;
    if (e0) begin
      m_we = (req0_addr != 0); m_wa = req0_addr; m_wd = req0_data;
    end else if (e1) begin
      m_we = (req1_addr != 0); m_wa = req1_addr; m_wd = req1_data;
    end else begin
      m_we = 1'b0;
    end
    @(posedge clk);
    #1;
    chk({tag, ":rf_we"}, rf_we, m_we);
    if (m_we) begin
      chk({tag, ":rf_wa"}, rf_wa, m_wa);
      chk({tag, ":rf_wd"}, rf_wd, m_wd);
    end
    if (rf_we === 1'b1) wr_count++;
  endtask

  task automatic idle(input string tag);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rsv_valid  = 1'b0;
    cycle(tag);
  endtask

  initial begin
    int budget;
    model_reset();

    // Reset held with a request pending
    req0_valid = 1'b1; req0_addr = 5'd7; req0_data = 32'd123;
    #2;
    chk("rst:req0_ready", req0_ready, 1'b0);
    chk("rst:rf_we", rf_we, 1'b0);
    chk("rst:rf_wa", rf_wa, 0);
    chk("rst:rf_wd", rf_wd, 0);
    chk("rst:stall", stall, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // Single req0 write x7=123, then hold of wa/wd across an idle cycle
    cycle("x7");
    chk("x7:wa", rf_wa, 7);
    chk("x7:wd", rf_wd, 123);
    idle("x7_idle");
    chk("hold:wa", rf_wa, 7);
    chk("hold:wd", rf_wd, 123);

    // Single req1 write x5
    req1_valid = 1'b1; req1_addr = 5'd5; req1_data = 32'hDEAD_BEEF;
    cycle("x5");
    chk("x5:wd", rf_wd, 32'hDEAD_BEEF);
    idle("x5_idle");

    // Contention: both sides hold four writes each
    wr_count = 0;
    glog = '0;
    for (int i = 1; i <= 4; i++) begin
      q0.push_back('{a: AWIDTH'(i), d: 32'h100 + i});
      q1.push_back('{a: AWIDTH'(i + 10), d: 32'h200 + i});
    end
    budget = 20;
    while ((q0.size() > 0 || q1.size() > 0) && budget > 0) begin
      drive_heads();
      cycle("contend");
      pop_granted();
      budget--;
    end
    chk("contend:drained", budget > 0, 1'b1);
    chk("contend:grant_pattern", glog, 8'b1010_1010);
    chk("contend:write_count", wr_count, 8);
    idle("contend_idle");

    // x0: granted, no write, no reservation
    req0_valid = 1'b1; req0_addr = 5'd0; req0_data = 32'd55;
    rsv_valid = 1'b1; rsv_addr = 5'd0; ra1 = 5'd0;
    cycle("x0");
    chk("x0:rf_we", rf_we, 1'b0);
    idle("x0_idle");
    chk("x0:stall", stall, 1'b0);

    // Hazard on x9 through commit; ra1=9/ra2=10 mirrors the same timing
    rsv_valid = 1'b1; rsv_addr = 5'd9; ra2 = 5'd9;
    cycle("hz_rsv");
    rsv_valid = 1'b0;
    chk("hz:stall_after_rsv", stall, 1'b1);
    req0_valid = 1'b1; req0_addr = 5'd9; req0_data = 32'h9999;
    cycle("hz_wr");
    req0_valid = 1'b0;
    ra1 = 5'd9; ra2 = 5'd10;
    chk("hz:stall_commit", stall, 1'b1);
    cycle("hz_commit");
    chk("hz:stall_after_commit", stall, 1'b0);
    idle("hz_idle");

    // Same-edge set and clear of x9: the reservation survives
    ra1 = 5'd0; ra2 = 5'd9;
    rsv_valid = 1'b1; rsv_addr = 5'd9;
    cycle("se_rsv");
    rsv_valid = 1'b0;
    req0_valid = 1'b1; req0_addr = 5'd9; req0_data = 32'h1;
    cycle("se_wr");
    req0_valid = 1'b0;
    rsv_valid = 1'b1; rsv_addr = 5'd9;
    cycle("se_commit");
    rsv_valid = 1'b0;
    chk("se:stall_kept", stall, 1'b1);
    idle("se_idle");
    chk("se:stall_still", stall, 1'b1);

    // Reset asserted mid-grant with a write in flight and x20 reserved
    rsv_valid = 1'b1; rsv_addr = 5'd20; ra1 = 5'd20;
    req0_valid = 1'b1; req0_addr = 5'd3; req0_data = 32'h33;
    cycle("mr_wr");
    rsv_valid = 1'b0;
    req0_addr = 5'd8; req0_data = 32'h88;
    #2;
    rst_n = 1'b0;
    #1;
    chk("mr:rf_we", rf_we, 1'b0);
    chk("mr:rf_wa", rf_wa, 0);
    chk("mr:rf_wd", rf_wd, 0);
    chk("mr:stall", stall, 1'b0);
    chk("mr:req0_ready", req0_ready, 1'b0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    req0_addr = 5'd7; req0_data = 32'd123;
    cycle("mr_x7");
    chk("mr_x7:wa", rf_wa, 7);
    chk("mr_x7:wd", rf_wd, 123);
    idle("mr_idle");

    // Randomized traffic
    q0.delete();
    q1.delete();
    for (int n = 0; n < 400; n++) begin
      if (q0.size() < 3 && $urandom_range(0, 1) == 1)
        q0.push_back('{a: AWIDTH'($urandom_range(0, NREG - 1)), d: $urandom});
      if (q1.size() < 3 && $urandom_range(0, 1) == 1)
        q1.push_back('{a: AWIDTH'($urandom_range(0, NREG - 1)), d: $urandom});
      rsv_valid = ($urandom_range(0, 3) == 0);
      rsv_addr  = AWIDTH'($urandom_range(0, NREG - 1));
      ra1       = AWIDTH'($urandom_range(0, NREG - 1));
      ra2       = AWIDTH'($urandom_range(0, NREG - 1));
      drive_heads();
      cycle("rand");
      pop_granted();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
